// File: rtl/ppu_entity_stage_if.sv
// Entity write channel between game logic (master) and the PPU entity staging stage (slave).
`timescale 1ns/1ps
interface ppu_entity_stage_if #(
  parameter int IDX_W    = 4,
  parameter int ENTITY_W = 14
) ();
  logic                wr_valid;
  logic                wr_ready;
  logic [IDX_W-1:0]    wr_index;
  logic [ENTITY_W-1:0] wr_data;
  logic                wr_last;

  modport master (
    output wr_valid,
    output wr_index,
    output wr_data,
    output wr_last,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_index,
    input  wr_data,
    input  wr_last,
    output wr_ready
  );
endinterface

// File: rtl/ppu_entity_stage.sv
// Frame-synchronous entity staging: writes land in a shadow bank, which is copied to the
// active bank only at a frame boundary so the frame buffer controller never sees a torn update.
// Also delays the pixel coordinate / video-enable stream by PIX_LAT cycles.
`timescale 1ns/1ps
module ppu_entity_stage #(
  parameter int                   NUM_ENTITIES = 9,
  parameter int                   ENTITY_W     = 14,
  parameter int                   IDX_W        = 4,
  parameter int                   PIX_LAT      = 1,
  parameter logic [ENTITY_W-1:0]  RESET_ENTITY = 14'h3C00
) (
  input  logic                             pixel_clk,
  input  logic                             reset,
  ppu_entity_stage_if.slave                wr_if,
  input  logic                             frame_start,
  output logic [NUM_ENTITIES*ENTITY_W-1:0] entities,
  output logic                             commit_pulse,
  output logic                             staged,
  output logic [7:0]                       skip_count,
  output logic                             index_err,
  input  logic [9:0]                       x_in,
  input  logic [9:0]                       y_in,
  input  logic                             de_in,
  output logic [9:0]                       x_out,
  output logic [9:0]                       y_out,
  output logic                             de_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STAGED = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Widened by one bit so the range check also works when NUM_ENTITIES == 2**IDX_W.
  localparam logic [IDX_W:0] NUM_IDX = (IDX_W+1)'(NUM_ENTITIES);

  state_t                                  state_q, state_d;
  logic [NUM_ENTITIES-1:0][ENTITY_W-1:0]   shadow_q, shadow_d;
  logic [NUM_ENTITIES-1:0][ENTITY_W-1:0]   active_q, active_d;
  logic                                    wr_ready_q, wr_ready_d;
  logic                                    commit_pulse_q, commit_pulse_d;
  logic                                    staged_q, staged_d;
  logic [7:0]                              skip_count_q, skip_count_d;
  logic                                    index_err_q, index_err_d;

  logic [9:0]                              x_pipe_q [PIX_LAT];
  logic [9:0]                              x_pipe_d [PIX_LAT];
  logic [9:0]                              y_pipe_q [PIX_LAT];
  logic [9:0]                              y_pipe_d [PIX_LAT];
  logic                                    de_pipe_q [PIX_LAT];
  logic                                    de_pipe_d [PIX_LAT];

  logic                                    wr_fire_s;
  logic                                    in_range_s;

  assign wr_fire_s  = wr_if.wr_valid && wr_ready_q;
  assign in_range_s = ({1'b0, wr_if.wr_index} < NUM_IDX);

  // Shadow-bank writes, index error tracking and the staging FSM next state.
  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    skip_count_d = skip_count_q;
    index_err_d  = index_err_q;

    if (wr_fire_s) begin
      if (in_range_s) begin
        for (int k = 0; k < NUM_ENTITIES; k++) begin
          if (wr_if.wr_index == IDX_W'(k)) begin
            shadow_d[k] = wr_if.wr_data;
          end else begin
            shadow_d[k] = shadow_q[k];
          end
        end
      end else begin
        index_err_d = 1'b1;
      end
    end else begin
      shadow_d = shadow_q;
    end

    case (state_q)
      IDLE: begin
        if (wr_fire_s && wr_if.wr_last) begin
          if (frame_start) begin
            // Closing write and frame boundary coincide: commit it straight away.
            state_d  = COMMIT;
            active_d = shadow_d;
          end else begin
            state_d = STAGED;
          end
        end else if (frame_start) begin
          if (skip_count_q != 8'hFF) begin
            skip_count_d = skip_count_q + 8'd1;
          end else begin
            skip_count_d = skip_count_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      STAGED: begin
        if (frame_start) begin
          state_d  = COMMIT;
          active_d = shadow_d;
        end else begin
          state_d = STAGED;
        end
      end
      COMMIT: begin
        // A frame_start here is deliberately ignored and not counted as a skip.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    wr_ready_d     = (state_d == IDLE);
    staged_d       = (state_d == STAGED);
    commit_pulse_d = (state_d == COMMIT);
  end

  // State, banks and status flags.
  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      shadow_q       <= {NUM_ENTITIES{RESET_ENTITY}};
      active_q       <= {NUM_ENTITIES{RESET_ENTITY}};
      wr_ready_q     <= 1'b1;
      commit_pulse_q <= 1'b0;
      staged_q       <= 1'b0;
      skip_count_q   <= 8'd0;
      index_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      wr_ready_q     <= wr_ready_d;
      commit_pulse_q <= commit_pulse_d;
      staged_q       <= staged_d;
      skip_count_q   <= skip_count_d;
      index_err_q    <= index_err_d;
    end
  end

  // Pixel pipe next values: stage 0 takes the input, each later stage the one before it.
  always_comb begin
    for (int i = 0; i < PIX_LAT; i++) begin
      if (i == 0) begin
        x_pipe_d[i]  = x_in;
        y_pipe_d[i]  = y_in;
        de_pipe_d[i] = de_in;
      end else begin
        x_pipe_d[i]  = x_pipe_q[i-1];
        y_pipe_d[i]  = y_pipe_q[i-1];
        de_pipe_d[i] = de_pipe_q[i-1];
      end
    end
  end

  // Free-running pixel delay chain, independent of the staging FSM.
  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PIX_LAT; i++) begin
        x_pipe_q[i]  <= 10'd0;
        y_pipe_q[i]  <= 10'd0;
        de_pipe_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < PIX_LAT; i++) begin
        x_pipe_q[i]  <= x_pipe_d[i];
        y_pipe_q[i]  <= y_pipe_d[i];
        de_pipe_q[i] <= de_pipe_d[i];
      end
    end
  end

  assign wr_if.wr_ready = wr_ready_q;
  assign entities       = active_q;
  assign commit_pulse   = commit_pulse_q;
  assign staged         = staged_q;
  assign skip_count     = skip_count_q;
  assign index_err      = index_err_q;
  assign x_out          = x_pipe_q[PIX_LAT-1];
  assign y_out          = y_pipe_q[PIX_LAT-1];
  assign de_out         = de_pipe_q[PIX_LAT-1];

endmodule

// File: tb/tb_ppu_entity_stage.sv
// Self-checking bench for ppu_entity_stage: shadow/active bank model with a commit scoreboard,
// and a delay-line scoreboard for the pixel pipe (PIX_LAT = 3).
`timescale 1ns/1ps
module tb_ppu_entity_stage;
  localparam int N   = 9;
  localparam int W   = 14;
  localparam int IW  = 4;
  localparam int LAT = 3;

  logic              pixel_clk = 1'b0;
  logic              reset     = 1'b0;
  logic              frame_start = 1'b0;
  logic [N*W-1:0]    entities;
  logic              commit_pulse, staged, index_err;
  logic [7:0]        skip_count;
  logic [9:0]        x_in = 10'd0, y_in = 10'd0, x_out, y_out;
  logic              de_in = 1'b0, de_out;

  logic [N-1:0][W-1:0] sh_m, act_m;
  logic [N*W-1:0]      rst_bank;
  logic [N*W-1:0]      bank_q [$];
  logic [20:0]         pix_q [$];
  int                  n_vec = 0;
  int                  n_err = 0;

  ppu_entity_stage_if #(.IDX_W(IW), .ENTITY_W(W)) wr_if ();

  ppu_entity_stage #(
    .NUM_ENTITIES(N), .ENTITY_W(W), .IDX_W(IW), .PIX_LAT(LAT), .RESET_ENTITY(14'h3C00)
  ) dut (
    .pixel_clk(pixel_clk), .reset(reset), .wr_if(wr_if.slave), .frame_start(frame_start),
    .entities(entities), .commit_pulse(commit_pulse), .staged(staged),
    .skip_count(skip_count), .index_err(index_err),
    .x_in(x_in), .y_in(y_in), .de_in(de_in), .x_out(x_out), .y_out(y_out), .de_out(de_out)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      sh_m[k]  = 14'h3C00;
      act_m[k] = 14'h3C00;
    end
  endtask

  // One-cycle write transaction, optionally with frame_start on the same edge.
  task automatic drive_write(input logic [IW-1:0] idx, input logic [W-1:0] d,
                             input logic last, input logic fs);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_index = idx;
    wr_if.wr_data  = d;
    wr_if.wr_last  = last;
    frame_start    = fs;
    tick();
    wr_if.wr_valid = 1'b0;
    wr_if.wr_last  = 1'b0;
    frame_start    = 1'b0;
  endtask

  // Bounded wait for commit_pulse; cyc reports how many extra cycles it took.
  task automatic wait_commit(output int cyc);
    cyc = 0;
    while (!commit_pulse && cyc < 8) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    model_reset();
    n_vec++; if (entities !== rst_bank) begin n_err++; $display("FAIL reset_entities: got %h want %h", entities, rst_bank); end
    n_vec++; if (wr_if.wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_wr_ready: got %b want 1", wr_if.wr_ready); end
    n_vec++; if (de_out !== 1'b0 || x_out !== 10'd0) begin n_err++; $display("FAIL reset_pixel: got de=%b x=%0d want 0/0", de_out, x_out); end
    n_vec++; if (skip_count !== 8'd0) begin n_err++; $display("FAIL reset_skip: got %0d want 0", skip_count); end
    n_vec++; if (staged !== 1'b0 || commit_pulse !== 1'b0 || index_err !== 1'b0) begin n_err++; $display("FAIL reset_flags: got st=%b cp=%b ie=%b want 0", staged, commit_pulse, index_err); end
  endtask

  task automatic test_commit();
    int cyc;
    logic [N*W-1:0] exp_b;
    drive_write(4'd2, 14'h0123, 1'b1, 1'b0);
    sh_m[2] = 14'h0123;
    for (int c = 0; c < 4; c++) begin
      n_vec++; if (staged !== 1'b1 || wr_if.wr_ready !== 1'b0) begin n_err++; $display("FAIL staged_wait%0d: got st=%b rdy=%b want 1/0", c, staged, wr_if.wr_ready); end
      n_vec++; if (entities !== act_m) begin n_err++; $display("FAIL no_early_commit%0d: got %h want %h", c, entities, act_m); end
      tick();
    end
    act_m = sh_m;
    bank_q.push_back(act_m);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_commit(cyc);
    n_vec++; if (!commit_pulse || cyc != 0) begin n_err++; $display("FAIL commit_latency: got cp=%b after %0d cycles want 1 after 0", commit_pulse, cyc); end
    exp_b = bank_q.pop_front();
    n_vec++; if (entities !== exp_b) begin n_err++; $display("FAIL commit_bank: got %h want %h", entities, exp_b); end
    n_vec++; if (entities[41:28] !== 14'h0123) begin n_err++; $display("FAIL slot2: got %h want 0123", entities[41:28]); end
    tick();
    n_vec++; if (commit_pulse !== 1'b0 || wr_if.wr_ready !== 1'b1 || staged !== 1'b0) begin n_err++; $display("FAIL after_commit: got cp=%b rdy=%b st=%b want 0/1/0", commit_pulse, wr_if.wr_ready, staged); end
  endtask

  task automatic test_skip();
    int cyc;
    logic [N*W-1:0] exp_b;
    drive_write(4'd0, 14'h0A0A, 1'b0, 1'b0);
    sh_m[0] = 14'h0A0A;
    for (int f = 0; f < 3; f++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
    end
    n_vec++; if (skip_count !== 8'd3) begin n_err++; $display("FAIL skip_count: got %0d want 3", skip_count); end
    n_vec++; if (entities !== act_m) begin n_err++; $display("FAIL skip_bank_unchanged: got %h want %h", entities, act_m); end
    drive_write(4'd8, 14'h1888, 1'b1, 1'b0);
    sh_m[8] = 14'h1888;
    act_m = sh_m;
    bank_q.push_back(act_m);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_commit(cyc);
    n_vec++; if (!commit_pulse || cyc != 0) begin n_err++; $display("FAIL skip_commit_latency: got cp=%b after %0d want 1 after 0", commit_pulse, cyc); end
    exp_b = bank_q.pop_front();
    n_vec++; if (entities !== exp_b) begin n_err++; $display("FAIL skip_commit_bank: got %h want %h", entities, exp_b); end
    n_vec++; if (entities[13:0] !== 14'h0A0A || entities[125:112] !== 14'h1888) begin n_err++; $display("FAIL slots0_8: got %h/%h want 0a0a/1888", entities[13:0], entities[125:112]); end
    tick();
  endtask

  task automatic test_same_cycle();
    logic [N*W-1:0] exp_b;
    sh_m[5] = 14'h1555;
    act_m = sh_m;
    bank_q.push_back(act_m);
    drive_write(4'd5, 14'h1555, 1'b1, 1'b1);
    n_vec++; if (staged !== 1'b0 || commit_pulse !== 1'b1) begin n_err++; $display("FAIL direct_commit: got st=%b cp=%b want 0/1", staged, commit_pulse); end
    exp_b = bank_q.pop_front();
    n_vec++; if (entities !== exp_b) begin n_err++; $display("FAIL direct_bank: got %h want %h", entities, exp_b); end
    n_vec++; if (skip_count !== 8'd3) begin n_err++; $display("FAIL direct_skip: got %0d want 3", skip_count); end
    tick();
    n_vec++; if (staged !== 1'b0 || commit_pulse !== 1'b0 || wr_if.wr_ready !== 1'b1) begin n_err++; $display("FAIL direct_after: got st=%b cp=%b rdy=%b want 0/0/1", staged, commit_pulse, wr_if.wr_ready); end
  endtask

  task automatic test_index_err();
    int cyc;
    logic [N*W-1:0] exp_b;
    drive_write(4'd9, 14'h2AAA, 1'b0, 1'b0);
    n_vec++; if (index_err !== 1'b1) begin n_err++; $display("FAIL index_err: got %b want 1", index_err); end
    n_vec++; if (entities !== act_m) begin n_err++; $display("FAIL index_err_bank: got %h want %h", entities, act_m); end
    drive_write(4'd1, 14'h0111, 1'b1, 1'b0);
    sh_m[1] = 14'h0111;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_index = 4'd1;
    wr_if.wr_data  = 14'h3FFF;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++; if (wr_if.wr_ready !== 1'b0) begin n_err++; $display("FAIL staged_ready%0d: got %b want 0", c, wr_if.wr_ready); end
    end
    act_m = sh_m;
    bank_q.push_back(act_m);
    frame_start = 1'b1;
    tick();
    frame_start    = 1'b0;
    wr_if.wr_valid = 1'b0;
    wait_commit(cyc);
    exp_b = bank_q.pop_front();
    n_vec++; if (!commit_pulse || entities !== exp_b) begin n_err++; $display("FAIL blocked_write_bank: got cp=%b %h want 1 %h", commit_pulse, entities, exp_b); end
    tick();
  endtask

  task automatic test_reset_staged();
    drive_write(4'd3, 14'h0333, 1'b1, 1'b0);
    n_vec++; if (staged !== 1'b1) begin n_err++; $display("FAIL pre_reset_staged: got %b want 1", staged); end
    reset = 1'b0;
    #2;
    model_reset();
    n_vec++; if (staged !== 1'b0 || wr_if.wr_ready !== 1'b1 || index_err !== 1'b0) begin n_err++; $display("FAIL async_reset_flags: got st=%b rdy=%b ie=%b want 0/1/0", staged, wr_if.wr_ready, index_err); end
    n_vec++; if (entities !== rst_bank) begin n_err++; $display("FAIL async_reset_bank: got %h want %h", entities, rst_bank); end
    tick();
    reset = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n_vec++; if (commit_pulse !== 1'b0 || skip_count !== 8'd1 || staged !== 1'b0) begin n_err++; $display("FAIL discard_staged: got cp=%b skip=%0d st=%b want 0/1/0", commit_pulse, skip_count, staged); end
    tick();
    n_vec++; if (commit_pulse !== 1'b0 || entities !== rst_bank) begin n_err++; $display("FAIL discard_bank: got cp=%b %h want 0 %h", commit_pulse, entities, rst_bank); end
  endtask

  task automatic test_pixel_pipe();
    logic [20:0] exp_p;
    pix_q.delete();
    for (int i = 0; i < 20; i++) begin
      x_in  = 10'(i * 7 + 3);
      y_in  = 10'(1000 - i);
      de_in = i[0];
      pix_q.push_back({de_in, y_in, x_in});
      tick();
      if (pix_q.size() == LAT) begin
        exp_p = pix_q.pop_front();
        n_vec++; if ({de_out, y_out, x_out} !== exp_p) begin n_err++; $display("FAIL pixel_pipe%0d: got %h want %h", i, {de_out, y_out, x_out}, exp_p); end
      end
    end
  endtask

  initial begin
    rst_bank       = {N{14'h3C00}};
    wr_if.wr_valid = 1'b0;
    wr_if.wr_index = 4'd0;
    wr_if.wr_data  = 14'd0;
    wr_if.wr_last  = 1'b0;
    model_reset();
    test_reset();
    test_commit();
    test_skip();
    test_same_cycle();
    test_index_err();
    test_reset_staged();
    test_pixel_pipe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
